bi_mem_arbiter: RTL and testbench
=================================

Name: bi_mem_arbiter

Overview:
Shares one single-port BiMem instance between PORTS requesters using round-robin arbitration with a valid/ready request handshake. It drives the memory from a registered command stage, honours the memory's hold output as a stall, and routes read data back to the issuing requester. It sits directly in front of BiMem in any subsystem where several masters need one memory macro.

Parameters:
PORTS, 4, number of requesters; 2..16.
WIDTH, 16, data width; passed through to BiMem.
HEIGHT, 16, memory depth in words; AW = $clog2(HEIGHT).
PROFILE, "default", forwarded unchanged to the BiMem instance at integration.

Ports:
clk_i  in  1  clock; all logic rising-edge.
rst_ni  in  1  asynchronous active-low reset.
reqValid_i  in  PORTS  per-port request valid.
reqReady_o  out  PORTS  per-port request accepted, one-hot or zero.
reqWrite_i  in  PORTS  per-port 1=write, 0=read.
reqAddr_i  in  PORTS*AW  per-port address; port p occupies bits [p*AW +: AW].
reqWData_i  in  PORTS*WIDTH  per-port write data.
rspValid_o  out  PORTS  one-hot read-data-valid strobe.
rspData_o  out  WIDTH  read data, shared by all ports; qualified by rspValid_o.
memEnable_o  out  1  to BiMem enable_i.
memIsWrite_o  out  1  to BiMem isWrite_i.
memAddr_o  out  AW  to BiMem addr_i.
memWData_o  out  WIDTH  to BiMem writeData_i.
memRData_i  in  WIDTH  from BiMem readData_o.
memHold_i  in  1  from BiMem hold_o; 1 = command not taken this cycle.

Behaviour:
- Reset: all outputs are 0 (reqReady_o, rspValid_o, memEnable_o, memIsWrite_o, memAddr_o, memWData_o); RR pointer = 0; FSM = IDLE; pending-read flag cleared. Reset mid-transfer drops the command and any pending response silently.
- Request handshake: a transfer occurs on a cycle with reqValid_i[p] && reqReady_o[p]. Requesters hold valid and fields stable until ready. reqReady_o never depends on memHold_i in the same port's favour except through `slot free`. reqReady_o is 0 for ports with valid=0.
- Command register: cmdValid/cmdWrite/cmdAddr/cmdWData/cmdPort. The memory outputs are driven from this register. memEnable_o = cmdValid.
- Memory acceptance: accepted = cmdValid && !memHold_i.
- Slot free: slotFree = !cmdValid || accepted.
- FSM IDLE (cmdValid=0): if any valid, grant the winner, load the command register, and go to CMD.
- FSM CMD: if memHold_i=1, stay, and keep all mem outputs stable.
- FSM CMD, accepted with a new winner present: load the next command in the same cycle, giving back-to-back throughput of 1 per cycle.
- FSM CMD, accepted with no requester: go to IDLE.
- Arbitration: round-robin starting at pointer ptr. Winner = first p in ptr, ptr+1, ... (mod PORTS) with valid. The grant is issued only when slotFree. After a grant to k, ptr = (k+1) mod PORTS. The pointer is unchanged when there is no grant.
- Read response: an accepted read sets pendValid/pendPort for exactly the next cycle. rspValid_o[pendPort] = pendValid. rspData_o = memRData_i, combinational pass-through.
- Read latency: handshake at cycle T, memEnable_o at T+1, rspValid_o at T+2 if no hold. Each hold cycle adds 1.
- Writes generate no response.
- Simultaneous accept and pending response are independent, so reads may stream.
- Address is not range-checked; an address >= HEIGHT is passed unchanged.

Optional Feature:
Macro BI_MEM_ARB_STATS_EN.
- When defined, adds output statConflict_o (16 bits). It is a saturating count (sticks at 0xFFFF) of cycles in which at least 2 reqValid_i bits are high and slotFree.
- It is cleared only by reset.
- When undefined, the port and the counter do not exist.

Decomposition:
- Package bi_mem_arb_pkg holds: the state enum (IDLE, CMD), and a function rr_pick(valid, ptr) returning the winner index plus a found flag.
- One sub-module, bi_rr_arbiter (PORTS), holds: the pointer register, the combinational pick, and a grant-enable input. It is reusable elsewhere.

Test Plan:
- Single read: port 2 reads addr 5, preloaded with 0xBEEF, no hold. Required: reqReady_o=0b0100 at T, memEnable_o at T+1, rspValid_o=0b0100 with rspData_o=0xBEEF at T+2.
- Fairness: all 4 ports stream valid reads, ptr=0 after reset. Required: grants in order 0,1,2,3,0,1,... with one grant per cycle; port 0 is never granted twice in a row.
- Hold stall: read issued, memHold_i=1 for 3 cycles. Required: mem outputs stable for 3 cycles, no reqReady_o during the stall, rspValid_o exactly 1 cycle after hold drops.
- Write then read: port 0 writes 0x1234 to addr 3, then port 1 reads addr 3 back-to-back. Required: no rspValid_o for the write, port 1 gets 0x1234.
- Reset mid-op: assert rst_ni=0 while CMD is held with pendValid=1. Required: all outputs 0 immediately (async); after release, first grant goes to the lowest valid port (ptr=0).
- Stats (BI_MEM_ARB_STATS_EN): ports 0 and 1 both valid for 10 cycles with no hold. Required: statConflict_o=10 (or the count of contended slot-free cycles); saturation holds at 0xFFFF.

Source files
------------

// File: rtl/bi_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// bi_mem_arb_pkg
// Shared types and helpers for the BiMem round-robin arbiter.
//   arb_state_e : command-slot FSM state (IDLE = slot empty, CMD = slot loaded)
//   rr_pick_t   : result of a round-robin search (found flag + winner index)
//   rr_pick()   : first valid requester at or after ptr, modulo ports
// Optional feature macro used by the top level: BI_MEM_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package bi_mem_arb_pkg;

  // Index width is fixed at the largest supported port count so that the
  // helper can be shared by every instance regardless of PORTS.
  localparam int unsigned RR_MAX_PORTS = 16;
  localparam int unsigned RR_IDX_W     = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CMD  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ... (mod ports) and return the first valid index.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX_PORTS-1:0] valid,
    input logic [RR_IDX_W-1:0]     ptr,
    input int unsigned             ports
  );
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < RR_MAX_PORTS; i++) begin
      cand = (32'(ptr) + i) % ports;
      if (i < ports && !res.found && valid[cand[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bi_rr_arbiter
// Generic round-robin arbiter with a grant-enable input.
//   clk_i, rst_ni : clock / asynchronous active-low reset
//   valid_i       : per-port request valid
//   grant_en_i    : a grant may be issued this cycle
//   grant_o       : one-hot grant (zero when disabled or nothing valid)
//   found_o       : some port is valid (independent of grant_en_i)
//   idx_o         : winning port index
// The pointer advances past the winner only on an actual grant.
// -----------------------------------------------------------------------------
module bi_rr_arbiter
  import bi_mem_arb_pkg::*;
#(
  parameter int PORTS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PORTS-1:0]    valid_i,
  input  logic                grant_en_i,
  output logic [PORTS-1:0]    grant_o,
  output logic                found_o,
  output logic [RR_IDX_W-1:0] idx_o
);

  logic [RR_IDX_W-1:0] r_ptr;
  rr_pick_t            w_pick;
  logic                w_fire;

  assign w_pick  = rr_pick(16'(valid_i), r_ptr, PORTS);
  assign found_o = w_pick.found;
  assign idx_o   = w_pick.idx;
  assign w_fire  = grant_en_i & w_pick.found;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_grant
    assign grant_o[gi] = w_fire && (w_pick.idx == RR_IDX_W'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= (w_pick.idx == RR_IDX_W'(PORTS - 1)) ? '0 : w_pick.idx + RR_IDX_W'(1);
    end
  end

endmodule

// File: rtl/bi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bi_mem_arbiter
// Shares one single-port BiMem between PORTS requesters (round robin).
//   clk_i, rst_ni            : clock / asynchronous active-low reset
//   reqValid_i / reqReady_o  : per-port request handshake (ready one-hot)
//   reqWrite_i, reqAddr_i,
//   reqWData_i               : per-port command fields (packed per port)
//   rspValid_o, rspData_o    : one-hot read strobe + shared read data
//   mem*_o / mem*_i          : BiMem command port, read data and hold
//   statConflict_o           : only with BI_MEM_ARB_STATS_EN; saturating
//                              count of contended slot-free cycles
// Memory outputs come straight from a command register; a new command is
// loaded whenever the slot is empty or the current one is being taken.
// PROFILE is carried only so integration can forward it to BiMem.
// -----------------------------------------------------------------------------
module bi_mem_arbiter
  import bi_mem_arb_pkg::*;
#(
  parameter int    PORTS   = 4,
  parameter int    WIDTH   = 16,
  parameter int    HEIGHT  = 16,
  parameter string PROFILE = "default",
  localparam int   AW      = $clog2(HEIGHT)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [PORTS-1:0]       reqValid_i,
  output logic [PORTS-1:0]       reqReady_o,
  input  logic [PORTS-1:0]       reqWrite_i,
  input  logic [PORTS*AW-1:0]    reqAddr_i,
  input  logic [PORTS*WIDTH-1:0] reqWData_i,
  output logic [PORTS-1:0]       rspValid_o,
  output logic [WIDTH-1:0]       rspData_o,
  output logic                   memEnable_o,
  output logic                   memIsWrite_o,
  output logic [AW-1:0]          memAddr_o,
  output logic [WIDTH-1:0]       memWData_o,
  input  logic [WIDTH-1:0]       memRData_i,
  input  logic                   memHold_i
`ifdef BI_MEM_ARB_STATS_EN
  ,
  output logic [15:0]            statConflict_o
`endif
);

  arb_state_e          r_state;
  logic                r_cmd_write;
  logic [AW-1:0]       r_cmd_addr;
  logic [WIDTH-1:0]    r_cmd_wdata;
  logic [RR_IDX_W-1:0] r_cmd_port;
  logic                r_pend_valid;
  logic [RR_IDX_W-1:0] r_pend_port;

  logic                w_cmd_valid;
  logic                w_accepted;
  logic                w_slot_free;
  logic                w_grant_en;
  logic [PORTS-1:0]    w_grant;
  logic                w_found;
  logic                w_grant_any;
  logic [RR_IDX_W-1:0] w_idx;
  logic                w_sel_write;
  logic [AW-1:0]       w_sel_addr;
  logic [WIDTH-1:0]    w_sel_wdata;

  assign w_cmd_valid = (r_state == ST_CMD);
  assign w_accepted  = w_cmd_valid & ~memHold_i;
  assign w_slot_free = ~w_cmd_valid | w_accepted;
  // Reset is folded in so ready stays low while the block is held in reset.
  assign w_grant_en  = w_slot_free & rst_ni;
  assign w_grant_any = w_found & w_grant_en;

  bi_rr_arbiter #(
    .PORTS (PORTS)
  ) u_rr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (reqValid_i),
    .grant_en_i (w_grant_en),
    .grant_o    (w_grant),
    .found_o    (w_found),
    .idx_o      (w_idx)
  );

  // Select the winning port's fields with the one-hot grant.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel_write = reqWrite_i[p];
        w_sel_addr  = reqAddr_i[p*AW +: AW];
        w_sel_wdata = reqWData_i[p*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_cmd_port   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_port  <= '0;
    end else begin
      // A read taken this cycle has its data on memRData_i next cycle.
      r_pend_valid <= w_accepted & ~r_cmd_write;
      r_pend_port  <= r_cmd_port;

      if (w_grant_any) begin
        r_cmd_write <= w_sel_write;
        r_cmd_addr  <= w_sel_addr;
        r_cmd_wdata <= w_sel_wdata;
        r_cmd_port  <= w_idx;
      end

      case (r_state)
        ST_IDLE: if (w_grant_any) r_state <= ST_CMD;
        ST_CMD:  if (w_accepted && !w_grant_any) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reqReady_o   = w_grant;
  assign memEnable_o  = w_cmd_valid;
  assign memIsWrite_o = r_cmd_write;
  assign memAddr_o    = r_cmd_addr;
  assign memWData_o   = r_cmd_wdata;
  assign rspData_o    = memRData_i;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_rsp
    assign rspValid_o[gi] = r_pend_valid && (r_pend_port == RR_IDX_W'(gi));
  end

`ifdef BI_MEM_ARB_STATS_EN
  logic [15:0] r_stat_conflict;
  logic        w_multi_valid;

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign w_multi_valid = |(reqValid_i & (reqValid_i - PORTS'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_conflict <= '0;
    end else if (w_multi_valid && w_slot_free && r_stat_conflict != 16'hFFFF) begin
      r_stat_conflict <= r_stat_conflict + 16'd1;
    end
  end

  assign statConflict_o = r_stat_conflict;
`endif

endmodule

// File: tb/tb_bi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bi_mem_arbiter
// Directed + random bench for bi_mem_arbiter with a BiMem stand-in
// (registered read, random hold) and a transaction-level reference model.
// Set BI_MEM_ARB_STATS_EN to also check statConflict_o.
// -----------------------------------------------------------------------------
module tb_bi_mem_arbiter;

  localparam int P  = 4;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int AW = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [P-1:0]    reqValid_i = '0;
  logic [P-1:0]    reqReady_o;
  logic [P-1:0]    reqWrite_i = '0;
  logic [P*AW-1:0] reqAddr_i = '0;
  logic [P*W-1:0]  reqWData_i = '0;
  logic [P-1:0]    rspValid_o;
  logic [W-1:0]    rspData_o;
  logic            memEnable_o;
  logic            memIsWrite_o;
  logic [AW-1:0]   memAddr_o;
  logic [W-1:0]    memWData_o;
  logic [W-1:0]    memRData_i;
  logic            memHold_i = 1'b0;
`ifdef BI_MEM_ARB_STATS_EN
  logic [15:0]     statConflict_o;
`endif

  always #5 clk_i = ~clk_i;

  bi_mem_arbiter #(.PORTS(P), .WIDTH(W), .HEIGHT(H)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .reqValid_i   (reqValid_i),
    .reqReady_o   (reqReady_o),
    .reqWrite_i   (reqWrite_i),
    .reqAddr_i    (reqAddr_i),
    .reqWData_i   (reqWData_i),
    .rspValid_o   (rspValid_o),
    .rspData_o    (rspData_o),
    .memEnable_o  (memEnable_o),
    .memIsWrite_o (memIsWrite_o),
    .memAddr_o    (memAddr_o),
    .memWData_o   (memWData_o),
    .memRData_i   (memRData_i),
    .memHold_i    (memHold_i)
`ifdef BI_MEM_ARB_STATS_EN
    ,
    .statConflict_o (statConflict_o)
`endif
  );

  // BiMem stand-in: command taken when enabled and not held, read data
  // appears on the following cycle.
  logic [W-1:0] mem [H];
  logic [W-1:0] mem_rdata = '0;
  always @(posedge clk_i) begin
    if (memEnable_o && !memHold_i) begin
      if (memIsWrite_o) mem[memAddr_o] <= memWData_o;
      else              mem_rdata      <= mem[memAddr_o];
    end
  end
  assign memRData_i = mem_rdata;

  // Reference model state
  int           errors = 0;
  int           checks = 0;
  int           m_ptr = 0;
  bit           m_cmd_v = 0;
  bit           m_cmd_w = 0;
  int           m_cmd_a = 0;
  logic [W-1:0] m_cmd_d = '0;
  int           m_cmd_p = 0;
  bit           m_pend_v = 0;
  int           m_pend_p = 0;
  logic [W-1:0] m_pend_d = '0;
  logic [W-1:0] m_mem [H];
  logic [15:0]  m_stat = '0;
  logic [P-1:0] fire = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    reqWrite_i[p]          = wr;
    reqAddr_i[p*AW +: AW]  = a;
    reqWData_i[p*W +: W]   = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cmd_v = 0; m_pend_v = 0; m_stat = '0;
  endtask

  // Evaluate one cycle at the falling edge: compare, then advance the model.
  task automatic model_step();
    int           winner;
    int           p;
    bit           slot_free;
    bit           accepted;
    logic [P-1:0] exp_ready;
    logic [P-1:0] exp_rsp;
    winner    = -1;
    slot_free = !m_cmd_v || !memHold_i;
    if (slot_free) begin
      for (int k = 0; k < P; k++) begin
        p = (m_ptr + k) % P;
        if (winner < 0 && reqValid_i[p]) winner = p;
      end
    end
    exp_ready = '0;
    if (winner >= 0) exp_ready[winner] = 1'b1;
    chk("ready", 32'(reqReady_o), 32'(exp_ready));
    chk("mem_en", 32'(memEnable_o), 32'(m_cmd_v));
    if (m_cmd_v) begin
      chk("mem_wr", 32'(memIsWrite_o), 32'(m_cmd_w));
      chk("mem_addr", 32'(memAddr_o), 32'(m_cmd_a));
      if (m_cmd_w) chk("mem_wdata", 32'(memWData_o), 32'(m_cmd_d));
    end
    exp_rsp = '0;
    if (m_pend_v) exp_rsp[m_pend_p] = 1'b1;
    chk("rsp_valid", 32'(rspValid_o), 32'(exp_rsp));
    if (m_pend_v) chk("rsp_data", 32'(rspData_o), 32'(m_pend_d));
`ifdef BI_MEM_ARB_STATS_EN
    chk("stat", 32'(statConflict_o), 32'(m_stat));
    if ($countones(reqValid_i) >= 2 && slot_free && m_stat != 16'hFFFF) m_stat++;
`endif
    fire = reqReady_o & reqValid_i;
    if (winner >= 0)
      $display("xfer port=%0d %s addr=%0h wdata=%0h", winner,
               reqWrite_i[winner] ? "WR" : "RD", reqAddr_i[winner*AW +: AW],
               reqWData_i[winner*W +: W]);

    accepted = m_cmd_v && !memHold_i;
    m_pend_v = accepted && !m_cmd_w;
    if (m_pend_v) begin
      m_pend_p = m_cmd_p;
      m_pend_d = m_mem[m_cmd_a];
    end
    if (accepted && m_cmd_w) m_mem[m_cmd_a] = m_cmd_d;
    if (winner >= 0) begin
      m_cmd_v = 1;
      m_cmd_w = reqWrite_i[winner];
      m_cmd_a = int'(reqAddr_i[winner*AW +: AW]);
      m_cmd_d = reqWData_i[winner*W +: W];
      m_cmd_p = winner;
      m_ptr   = (winner + 1) % P;
    end else if (accepted) begin
      m_cmd_v = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] exp7;
    logic [P-1:0] exp_fair;

    for (int i = 0; i < H; i++) begin
      v = (i == 5) ? 16'hBEEF : 16'($urandom);
      mem[i]  <= v;
      m_mem[i] = v;
    end
    model_reset();

    // Reset state, with requests present to show ready is held off.
    rst_ni = 1'b0;
    reqValid_i = 4'b1111;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(reqReady_o), 32'h0);
    chk("rst_rsp", 32'(rspValid_o), 32'h0);
    chk("rst_en", 32'(memEnable_o), 32'h0);
    chk("rst_wr", 32'(memIsWrite_o), 32'h0);
    chk("rst_addr", 32'(memAddr_o), 32'h0);
    chk("rst_wdata", 32'(memWData_o), 32'h0);
    reqValid_i = '0;
    rst_ni = 1'b1;
    #1;

    // Single read: port 2, addr 5.
    set_req(2, 1'b0, 4'd5, '0);
    reqValid_i = 4'b0100;
    #1 chk("rd_t0_ready", 32'(reqReady_o), 32'h4);
    cycle();
    reqValid_i = '0;
    chk("rd_t1_en", 32'(memEnable_o), 32'h1);
    chk("rd_t1_addr", 32'(memAddr_o), 32'h5);
    chk("rd_t1_rsp", 32'(rspValid_o), 32'h0);
    cycle();
    chk("rd_t2_rsp", 32'(rspValid_o), 32'h4);
    chk("rd_t2_data", 32'(rspData_o), 32'hBEEF);
    cycle();

    // Write then read back-to-back (ptr now 3, so port 0 wins first).
    set_req(0, 1'b1, 4'd3, 16'h1234);
    set_req(1, 1'b0, 4'd3, '0);
    reqValid_i = 4'b0011;
    #1 chk("wr_ready0", 32'(reqReady_o), 32'h1);
    cycle();
    reqValid_i = 4'b0010;
    #1 chk("wr_ready1", 32'(reqReady_o), 32'h2);
    chk("wr_is_write", 32'(memIsWrite_o), 32'h1);
    cycle();
    reqValid_i = '0;
    chk("wr_no_rsp", 32'(rspValid_o), 32'h0);
    chk("rb_is_read", 32'(memIsWrite_o), 32'h0);
    cycle();
    chk("rb_rsp", 32'(rspValid_o), 32'h2);
    chk("rb_data", 32'(rspData_o), 32'h1234);
    cycle();

    // Hold stall: port 2 reads addr 7, memory holds for 3 cycles.
    exp7 = m_mem[7];
    set_req(2, 1'b0, 4'd7, '0);
    reqValid_i = 4'b0100;
    #1 chk("hold_ready", 32'(reqReady_o), 32'h4);
    cycle();
    set_req(3, 1'b1, 4'd9, 16'hA5A5);
    reqValid_i = 4'b1000;
    memHold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_en", 32'(memEnable_o), 32'h1);
      chk("hold_addr", 32'(memAddr_o), 32'h7);
      chk("hold_no_ready", 32'(reqReady_o), 32'h0);
      chk("hold_no_rsp", 32'(rspValid_o), 32'h0);
      cycle();
    end
    memHold_i = 1'b0;
    #1 chk("unhold_ready", 32'(reqReady_o), 32'h8);
    chk("unhold_no_rsp", 32'(rspValid_o), 32'h0);
    cycle();
    reqValid_i = '0;
    chk("unhold_rsp", 32'(rspValid_o), 32'h4);
    chk("unhold_data", 32'(rspData_o), 32'(exp7));
    cycle();
    cycle();

    // Random traffic with random hold.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < P; p++) begin
        if (!reqValid_i[p] || fire[p]) begin
          reqValid_i[p] = ($urandom_range(0, 2) != 0);
          set_req(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, H - 1)), 16'($urandom));
        end
      end
      memHold_i = ($urandom_range(0, 3) == 0);
      cycle();
    end
    reqValid_i = '0;
    memHold_i = 1'b0;
    repeat (3) cycle();

    // Reset while a command is held and a read response is pending.
    set_req(0, 1'b0, 4'd1, '0);
    set_req(1, 1'b0, 4'd2, '0);
    reqValid_i = 4'b0011;
    cycle();
    reqValid_i = reqValid_i & ~fire;
    cycle();
    reqValid_i = reqValid_i & ~fire;
    memHold_i = 1'b1;
    #1;
    chk("pre_rst_en", 32'(memEnable_o), 32'h1);
    chk("pre_rst_pend", 32'(|rspValid_o), 32'h1);
    reqValid_i = 4'b1111;
    rst_ni = 1'b0;
    #1;
    chk("arst_ready", 32'(reqReady_o), 32'h0);
    chk("arst_rsp", 32'(rspValid_o), 32'h0);
    chk("arst_en", 32'(memEnable_o), 32'h0);
    chk("arst_wr", 32'(memIsWrite_o), 32'h0);
    chk("arst_addr", 32'(memAddr_o), 32'h0);
    chk("arst_wdata", 32'(memWData_o), 32'h0);
    memHold_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Fairness: all ports streaming reads, grants rotate from port 0.
    for (int p = 0; p < P; p++) set_req(p, 1'b0, 4'(p + 8), '0);
    for (int i = 0; i < 8; i++) begin
      exp_fair = '0;
      exp_fair[i % P] = 1'b1;
      #1 chk("fair_grant", 32'(reqReady_o), 32'(exp_fair));
      cycle();
    end
    reqValid_i = '0;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
